// File: rtl/fetch_queue_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit_pkg
// Description : Shared constants, fetch FSM state encoding and queue entry
//               type for the instruction-fetch queue unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_unit_pkg;

  // Instruction presented downstream when nothing valid is queued.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  // Default boot vector.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  // FETCH: may issue; WAIT: one request outstanding, response is kept;
  // DROP: one request outstanding whose response must be thrown away.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  // One queue slot: instruction word plus the address it was fetched from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit_if
// Description : Instruction-memory request/response channel. The fetch unit
//               is the master; the instruction memory is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_unit_if;

  logic        Imem_Req_Valid;
  logic [31:0] Imem_Req_Addr;
  logic        Imem_Req_Ready;
  logic        Imem_Resp_Valid;
  logic [31:0] Imem_Resp_Data;

  modport master (
    output Imem_Req_Valid,
    output Imem_Req_Addr,
    input  Imem_Req_Ready,
    input  Imem_Resp_Valid,
    input  Imem_Resp_Data
  );

  modport slave (
    input  Imem_Req_Valid,
    input  Imem_Req_Addr,
    output Imem_Req_Ready,
    output Imem_Resp_Valid,
    output Imem_Resp_Data
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue_unit_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch-queue entries with push, pop,
//               clear, occupancy count and full/empty flags. A push and a pop
//               in the same cycle are both honoured, including when full.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_queue_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  fq_entry_t                    i_push_data,
  input  logic                         i_pop,
  input  logic                         i_clear,
  output fq_entry_t                    o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam int                 c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  fq_entry_t            r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_depth);
  assign w_do_pop  = i_pop && !o_empty;
  // A full queue can still accept a push when the head leaves this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Entry storage; contents are don't-care until the count covers them.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit
// Description : Instruction-fetch stage. Holds the PC, issues one outstanding
//               word request at a time to instruction memory, buffers the
//               returned words in a small queue feeding the IF/ID latch and
//               squashes queued and in-flight fetches on a redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          FQ_DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       STALL,
  input  logic                       Request_Alt_PC,
  input  logic [31:0]                Alt_PC,
  fetch_queue_unit_if.master         imem,
  output logic [31:0]                Instr1_IF,
  output logic [31:0]                Instr_PC_IF,
  output logic [31:0]                Instr_PC_Plus4_IF,
  output logic                       Instr_Valid_IF
);

  localparam int                 c_cnt_w = $clog2(FQ_DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FQ_DEPTH);

  fetch_state_t         r_state;
  fetch_state_t         w_state_next;
  logic [31:0]          r_pc;
  logic [31:0]          w_pc_next;
  logic [31:0]          r_req_pc;
  fq_entry_t            w_head;
  fq_entry_t            w_push_data;
  logic [c_cnt_w-1:0]   w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_req_valid;
  logic                 w_req_fire;
  logic                 w_enqueue;
  logic                 w_dequeue;

  // Only FETCH issues and nothing is in flight there, so the registered
  // count already accounts for every outstanding word.
  logic w_room;
  assign w_room = (w_count < c_depth);

  // A redirect flushes the queue, so nothing may leave it that cycle.
  assign w_dequeue   = !w_empty && !STALL && !Request_Alt_PC;
  assign w_req_fire  = w_req_valid && imem.Imem_Req_Ready;
  assign w_push_data = '{instr: imem.Imem_Resp_Data, pc: r_req_pc};

  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_fifo (
    .clk         (CLK),
    .rst         (RESET),
    .i_push      (w_enqueue),
    .i_push_data (w_push_data),
    .i_pop       (w_dequeue),
    .i_clear     (Request_Alt_PC),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // State, PC and the address of the outstanding request.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_req_fire) begin
        r_req_pc <= r_pc;
      end
    end
  end

  // Next state, next PC, request valid and enqueue decision.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_req_valid  = 1'b0;
    w_enqueue    = 1'b0;
    case (r_state)
      FETCH: begin
        // Held low during reset so no request can be accepted and lost.
        w_req_valid = w_room && !Request_Alt_PC && !RESET;
        if (w_req_valid && imem.Imem_Req_Ready) begin
          w_state_next = WAIT;
          w_pc_next    = r_pc + 32'd4;
        end
      end
      WAIT: begin
        if (imem.Imem_Resp_Valid) begin
          w_state_next = FETCH;
          w_enqueue    = !Request_Alt_PC;
        end else if (Request_Alt_PC) begin
          w_state_next = DROP;
        end
      end
      DROP: begin
        if (imem.Imem_Resp_Valid) begin
          w_state_next = FETCH;
        end
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
    if (Request_Alt_PC) begin
      w_pc_next = word_align(Alt_PC);
    end
  end

  assign imem.Imem_Req_Valid = w_req_valid;
  assign imem.Imem_Req_Addr  = r_pc;

  assign Instr_Valid_IF    = !w_empty;
  assign Instr1_IF         = w_empty ? NOP_INSTR : w_head.instr;
  assign Instr_PC_IF       = w_empty ? 32'd0     : w_head.pc;
  assign Instr_PC_Plus4_IF = w_empty ? 32'd0     : (w_head.pc + 32'd4);

  // Issue gating must make an enqueue into a full, non-draining queue
  // impossible.
  a_no_overflow: assert property (
    @(posedge CLK) disable iff (RESET) !(w_enqueue && w_full && !w_dequeue)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue_unit
// Description : Self-checking bench for fetch_queue_unit with a randomized
//               instruction memory and a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_queue_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam int          DEPTH  = 4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        CLK;
  logic        RESET;
  logic        STALL;
  logic        Request_Alt_PC;
  logic [31:0] Alt_PC;
  logic [31:0] Instr1_IF;
  logic [31:0] Instr_PC_IF;
  logic [31:0] Instr_PC_Plus4_IF;
  logic        Instr_Valid_IF;

  fetch_queue_unit_if imem_if ();

  fetch_queue_unit #(
    .RESET_PC (RST_PC),
    .FQ_DEPTH (DEPTH)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .STALL             (STALL),
    .Request_Alt_PC    (Request_Alt_PC),
    .Alt_PC            (Alt_PC),
    .imem              (imem_if),
    .Instr1_IF         (Instr1_IF),
    .Instr_PC_IF       (Instr_PC_IF),
    .Instr_PC_Plus4_IF (Instr_PC_Plus4_IF),
    .Instr_Valid_IF    (Instr_Valid_IF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_bad    = 0;
  int n_fire   = 0;

  // Reference model: delivered-instruction queue, next fetch address,
  // outstanding request and whether its response is still wanted.
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_req;
  bit          m_inflight;
  bit          m_cancel;

  // Instruction memory model.
  bit          mem_busy;
  int          mem_delay;
  logic [31:0] mem_addr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_alt();
    int unsigned k;
    k = $urandom_range(2, 0);
    case (k)
      0:       return $urandom;
      1:       return 32'hFFFF_FFF0 | ($urandom & 32'hF);
      default: return 32'h0040_0000 | ($urandom & 32'hFF);
    endcase
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance models.
  task automatic do_cycle(input bit r_in, input bit s_in, input bit a_in,
                          input logic [31:0] apc, input bit rdy,
                          input int lat_min, input int lat_max, output bit fired);
    bit          exp_rv;
    bit          resp_v;
    logic [31:0] resp_d;
    bit          fire;
    logic [31:0] fire_addr;
    ent_t        h;
    RESET          = r_in;
    STALL          = s_in;
    Request_Alt_PC = a_in;
    Alt_PC         = apc;
    imem_if.Imem_Req_Ready = rdy && !mem_busy;
    resp_v = mem_busy && (mem_delay == 0);
    resp_d = resp_v ? (mem_addr ^ 32'h0000_1234) : $urandom;
    imem_if.Imem_Resp_Valid = resp_v;
    imem_if.Imem_Resp_Data  = resp_d;
    #3;
    exp_rv = !r_in && !m_inflight && (mq.size() < DEPTH) && !a_in;
    check_val("req_valid", 32'(imem_if.Imem_Req_Valid), 32'(exp_rv));
    if (exp_rv) check_val("req_addr", imem_if.Imem_Req_Addr, m_pc);
    if (!r_in) begin
      if (mq.size() > 0) begin
        h = mq[0];
        check_val("instr_valid", 32'(Instr_Valid_IF), 32'd1);
        check_val("instr", Instr1_IF, h.instr);
        check_val("instr_pc", Instr_PC_IF, h.pc);
        check_val("instr_pc4", Instr_PC_Plus4_IF, h.pc + 32'd4);
      end else begin
        check_val("instr_valid", 32'(Instr_Valid_IF), 32'd0);
        check_val("instr_nop", Instr1_IF, 32'd0);
        check_val("instr_pc_zero", Instr_PC_IF, 32'd0);
        check_val("instr_pc4_zero", Instr_PC_Plus4_IF, 32'd0);
      end
    end
    fire      = imem_if.Imem_Req_Valid && imem_if.Imem_Req_Ready;
    fire_addr = imem_if.Imem_Req_Addr;
    fired     = fire;
    if (fire) n_fire++;
    @(posedge CLK);
    if (r_in) begin
      mq.delete();
      m_inflight = 0;
      m_cancel   = 0;
      m_pc       = RST_PC;
    end else if (a_in) begin
      mq.delete();
      m_pc = apc & ~32'h3;
      if (m_inflight) begin
        if (resp_v) begin
          m_inflight = 0;
          m_cancel   = 0;
        end else begin
          m_cancel = 1;
        end
      end
    end else begin
      if (mq.size() > 0 && !s_in) void'(mq.pop_front());
      if (m_inflight && resp_v) begin
        if (!m_cancel) mq.push_back('{instr: resp_d, pc: m_req});
        m_inflight = 0;
        m_cancel   = 0;
      end
      if (fire) begin
        m_inflight = 1;
        m_req      = m_pc;
        m_pc       = m_pc + 32'd4;
      end
    end
    if (resp_v) mem_busy = 0;
    else if (mem_busy) mem_delay--;
    if (fire) begin
      mem_busy  = 1;
      mem_addr  = fire_addr;
      mem_delay = int'($urandom_range(lat_max - 1, lat_min - 1));
    end
    #1;
  endtask

  task automatic run_phase(input int n, input int rst_pm, input int stall_p, input int alt_p,
                           input int rdy_p, input int lat_min, input int lat_max);
    bit f;
    for (int i = 0; i < n; i++) begin
      do_cycle(($urandom_range(999, 0) < rst_pm), ($urandom_range(99, 0) < stall_p),
               ($urandom_range(99, 0) < alt_p), pick_alt(),
               ($urandom_range(99, 0) < rdy_p), lat_min, lat_max, f);
    end
  endtask

  initial begin
    bit f;
    int guard;
    RESET = 1'b1; STALL = 1'b0; Request_Alt_PC = 1'b0; Alt_PC = '0;
    imem_if.Imem_Req_Ready = 1'b0; imem_if.Imem_Resp_Valid = 1'b0; imem_if.Imem_Resp_Data = '0;
    m_pc = RST_PC; m_req = '0; m_inflight = 0; m_cancel = 0;
    mem_busy = 0; mem_delay = 0; mem_addr = '0;

    // Reset, then free-run with single-cycle memory.
    do_cycle(1, 0, 0, 32'd0, 1, 1, 1, f);
    do_cycle(1, 0, 0, 32'd0, 1, 1, 1, f);
    for (int i = 0; i < 12; i++) do_cycle(0, 0, 0, 32'd0, 1, 1, 1, f);

    // Stall from reset: queue fills after exactly DEPTH requests.
    do_cycle(1, 0, 0, 32'd0, 1, 1, 1, f);
    do_cycle(1, 0, 0, 32'd0, 1, 1, 1, f);
    n_fire = 0;
    for (int i = 0; i < 10; i++) do_cycle(0, 1, 0, 32'd0, 1, 1, 1, f);
    check_val("stall_reqs", n_fire, 32'd4);
    for (int i = 0; i < 20; i++) do_cycle(0, 0, 0, 32'd0, 1, 1, 1, f);

    // Redirect two cycles into a 5-cycle memory wait.
    guard = 0; f = 0;
    while (!f && guard < 20) begin
      do_cycle(0, 0, 0, 32'd0, 1, 5, 5, f);
      guard++;
    end
    check_val("redir_wait_fire", 32'(f), 32'd1);
    do_cycle(0, 0, 0, 32'd0, 1, 5, 5, f);
    do_cycle(0, 0, 1, 32'h0040_0003, 1, 5, 5, f);
    for (int i = 0; i < 16; i++) do_cycle(0, 0, 0, 32'd0, 1, 5, 5, f);

    // Redirect coinciding with the response.
    guard = 0; f = 0;
    while (!f && guard < 20) begin
      do_cycle(0, 0, 0, 32'd0, 1, 1, 1, f);
      guard++;
    end
    check_val("redir_resp_fire", 32'(f), 32'd1);
    do_cycle(0, 0, 1, 32'h0040_0100, 1, 1, 1, f);
    for (int i = 0; i < 8; i++) do_cycle(0, 0, 0, 32'd0, 1, 1, 1, f);

    // Ready held low for three cycles.
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 32'd0, 0, 1, 1, f);
    for (int i = 0; i < 8; i++) do_cycle(0, 0, 0, 32'd0, 1, 1, 1, f);

    // Reset while waiting with two entries queued; late response is stray.
    do_cycle(1, 0, 0, 32'd0, 1, 4, 4, f);
    guard = 0;
    while (!(mq.size() == 2 && m_inflight) && guard < 60) begin
      do_cycle(0, 1, 0, 32'd0, 1, 4, 4, f);
      guard++;
    end
    check_val("pre_reset_valid", 32'(Instr_Valid_IF), 32'd1);
    do_cycle(1, 0, 0, 32'd0, 1, 4, 4, f);
    for (int i = 0; i < 16; i++) do_cycle(0, 0, 0, 32'd0, 1, 4, 4, f);

    // Randomized mixes.
    run_phase(400, 0, 20, 3, 80, 1, 1);
    run_phase(400, 0, 50, 5, 60, 1, 6);
    run_phase(400, 5, 30, 8, 70, 1, 4);
    run_phase(300, 0, 90, 2, 90, 1, 3);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline latch; produces Instr1_IF, Instr_PC_IF and Instr_PC_Plus4_IF for it.
- Holds the PC.
- Issues one-outstanding word requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions in a small FIFO so downstream STALL does not stall memory traffic.
- Handles branch/jump redirects by discarding queued and in-flight instructions.

Parameters:
RESET_PC, 32'hBFC00000, PC loaded on reset.
FQ_DEPTH, 4, fetch-queue entries (power of two, 2..16).

Ports:
CLK  in  1  clock; all state updates on posedge.
RESET  in  1  synchronous, active-high reset.
STALL  in  1  downstream hold; head entry is not consumed this cycle.
Request_Alt_PC  in  1  redirect request (branch/jump/exception).
Alt_PC  in  32  redirect target; bits [1:0] are forced to 0.
Imem_Req_Valid  out  1  request valid.
Imem_Req_Addr  out  32  word-aligned request address.
Imem_Req_Ready  in  1  memory accepts request when Valid&&Ready.
Imem_Resp_Valid  in  1  response valid, one cycle per accepted request, arbitrary latency ≥1.
Imem_Resp_Data  in  32  instruction word.
Instr1_IF  out  32  head instruction; 0 (NOP) when queue empty.
Instr_PC_IF  out  32  PC of head instruction; 0 when empty.
Instr_PC_Plus4_IF  out  32  head PC+4; 0 when empty.
Instr_Valid_IF  out  1  queue non-empty.

Behaviour:
- Reset, synchronous when RESET=1 at posedge:
  - PC=RESET_PC, queue empty, state=FETCH.
  - All outputs 0, except Imem_Req_Addr=RESET_PC.
  - Reset overrides every other input, including mid-transaction; a response arriving after reset while in FETCH is ignored.
- Queue entry = {instr, pc}. Outputs are combinational from the head entry. Instr_PC_Plus4_IF = pc+4, mod 2^32.
- Dequeue when Instr_Valid_IF && !STALL && !Request_Alt_PC.
- State machine:
  - FETCH:
    - Imem_Req_Valid=1 iff count < FQ_DEPTH (count = occupancy after this cycle's dequeue is not used; use registered count). Imem_Req_Addr=PC.
    - On Valid&&Ready: latch req_pc=PC, PC<=PC+4, go WAIT.
  - WAIT:
    - Imem_Req_Valid=0.
    - On Imem_Resp_Valid: enqueue {data, req_pc}, go FETCH.
    - Enqueue and dequeue in the same cycle keep count unchanged.
  - DROP:
    - Imem_Req_Valid=0.
    - On Imem_Resp_Valid: discard the response, go FETCH.
- Back-pressure: issue is gated by count < FQ_DEPTH evaluated with the in-flight request counted. No overflow is ever possible; an enqueue when full is a design error and gets an assertion.
- Redirect (Request_Alt_PC=1) has priority over STALL, dequeue and enqueue:
  - Queue cleared; PC<=Alt_PC&~3.
  - FETCH: no request accepted this cycle (Imem_Req_Valid forced 0); stay FETCH.
  - WAIT with no response this cycle: go DROP.
  - WAIT with Resp_Valid this cycle: response discarded; go FETCH.
  - DROP: stay DROP, or go FETCH if Resp_Valid this cycle. PC is updated either way.
  - First request from the new PC issues the cycle after the redirect at the earliest.
- Empty queue with STALL=0: outputs 0/NOP, Instr_Valid_IF=0; the downstream latch captures a bubble.
- PC wrap: 32'hFFFFFFFC+4 = 0, no special handling.
- Throughput: one instruction per 2 cycles with single-cycle memory (request, response).

Decomposition:
- Shared package: constants NOP_INSTR=32'h0 and RESET_PC default; fetch FSM state enum {FETCH, WAIT, DROP}; fq_entry_t struct {instr[31:0], pc[31:0]}.
- Natural sub-module: fetch_fifo. A parameterised synchronous FIFO with push, pop, clear, count, full and empty outputs, and same-cycle push+pop support. The FSM and PC logic stay in the top.

Test Plan:
- Reset then free-run, single-cycle memory returning addr^32'h1234, STALL=0 -> Imem_Req_Addr BFC00000, BFC00004…; Instr_PC_IF=BFC00000 with Instr1_IF=BFC00000^1234, Plus4=BFC00004.
- STALL=1 for 10 cycles from reset -> exactly 4 requests issued (queue fills, then Req_Valid=0). Head holds PC BFC00000. On release, PCs 0,4,8,C drain in order, then fetching resumes at BFC00010.
- Memory latency 5 cycles; Request_Alt_PC=1, Alt_PC=32'h00400003 two cycles into WAIT:
  - queue empties immediately;
  - late response is discarded (never on Instr1_IF);
  - next request address is 00400000.
- Redirect in the same cycle as Imem_Resp_Valid in WAIT -> response dropped, state FETCH, next request at Alt_PC one cycle later.
- Imem_Req_Ready low for 3 cycles -> Imem_Req_Addr stable, PC not advanced, no duplicate or skipped PCs.
- RESET asserted in WAIT with queue holding 2 entries -> next cycle Instr_Valid_IF=0, outputs 0, request to RESET_PC; a stray Resp_Valid in the FETCH state is ignored.
